// File: rtl/qspi_target_if.sv
// Pin bundle between the QSPI host and the target, plus the target's byte-wide memory port.
// The slave modport is the target's view; the master modport is the host/memory side.
interface qspi_target_if #(
    parameter int AW = 24
);
    logic          sclk_i;
    logic          cs_i;
    logic [3:0]    sd_i;
    logic [3:0]    sd_o;
    logic [3:0]    sd_oe;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;
    logic          mem_gnt_i;
    logic [7:0]    mem_rdata_i;
    logic          mem_rvalid_i;
    logic          busy_o;
    logic          err_o;

    modport slave (
        input  sclk_i, cs_i, sd_i, mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        output sd_o, sd_oe, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
    );

    modport master (
        output sclk_i, cs_i, sd_i, mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        input  sd_o, sd_oe, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
    );
endinterface

// File: rtl/qspi_target.sv
// QSPI device-side responder: oversamples host pins, decodes cmd/addr/dummy and streams
// bytes between the wire and a byte-wide memory port with auto-incrementing address.
//   state  | meaning
//   IDLE   | CS high, or waiting for an outstanding memory request to drain
//   CMD    | shifting in the 8-bit command on sd[0]
//   ADDR   | shifting in the 24-bit address on sd[0]
//   DUMMY  | quad-read turnaround cycles, first byte being fetched
//   RDATA  | shifting read bytes out on falling SCLK
//   WDATA  | assembling write bytes on rising SCLK
//   IGNORE | unsupported command, silent until CS high
module qspi_target #(
    parameter int AW    = 24,
    parameter int DUMMY = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    qspi_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY_S, RDATA, WDATA, IGNORE} state_t;

    state_t        state;
    logic [1:0]    sclk_sync;
    logic [1:0]    cs_sync;
    logic [3:0]    sd_m;
    logic [3:0]    sd_s;
    logic          sclk_d;
    logic          rise;
    logic          fall;
    logic [7:0]    cmd_sh;
    logic [22:0]   addr_sh;
    logic [23:0]   full_addr;
    logic [7:0]    cnt;
    logic [2:0]    bcnt;
    logic          quad;
    logic [7:0]    shreg;
    logic [7:0]    pbuf;
    logic [6:0]    wsh;
    logic [7:0]    wbyte;
    logic [AW-1:0] cur_addr;
    logic          rd_wait;
    logic          pending;

    always_comb begin
        rise      = sclk_sync[1] & ~sclk_d;
        fall      = ~sclk_sync[1] & sclk_d;
        full_addr = {addr_sh, sd_s[0]};
        wbyte     = quad ? {wsh[3:0], sd_s} : {wsh, sd_s[0]};
        pending   = bus.mem_req_o | rd_wait;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            sclk_sync       <= 2'b00;
            cs_sync         <= 2'b11;
            sd_m            <= 4'h0;
            sd_s            <= 4'h0;
            sclk_d          <= 1'b0;
            cmd_sh          <= 8'h00;
            addr_sh         <= 23'h0;
            cnt             <= 8'h00;
            bcnt            <= 3'd0;
            quad            <= 1'b0;
            shreg           <= 8'h00;
            pbuf            <= 8'h00;
            wsh             <= 7'h00;
            cur_addr        <= '0;
            rd_wait         <= 1'b0;
            bus.sd_o        <= 4'h0;
            bus.sd_oe       <= 4'h0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= 8'h00;
            bus.busy_o      <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], bus.sclk_i};
            cs_sync    <= {cs_sync[0], bus.cs_i};
            sd_m       <= bus.sd_i;
            sd_s       <= sd_m;
            sclk_d     <= sclk_sync[1];
            bus.err_o  <= 1'b0;
            bus.busy_o <= ~cs_sync[1] && (state != IGNORE);

            if (bus.mem_req_o && bus.mem_gnt_i) begin
                bus.mem_req_o <= 1'b0;
                if (!bus.mem_we_o) rd_wait <= 1'b1;
            end
            // Read data landing after an abort (state back in IDLE) is dropped.
            if (rd_wait && bus.mem_rvalid_i) begin
                rd_wait <= 1'b0;
                if (state == DUMMY_S || state == RDATA) pbuf <= bus.mem_rdata_i;
            end

            if (cs_sync[1]) begin
                state     <= IDLE;
                bus.sd_o  <= 4'h0;
                bus.sd_oe <= 4'h0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!pending) begin
                            state <= CMD;
                            cnt   <= 8'd7;
                        end
                    end
                    CMD: begin
                        if (rise) begin
                            cmd_sh <= {cmd_sh[6:0], sd_s[0]};
                            if (cnt == 8'd0) begin
                                state <= ADDR;
                                cnt   <= 8'd23;
                                case ({cmd_sh[6:0], sd_s[0]})
                                    8'h03, 8'h02: quad <= 1'b0;
                                    8'h6B, 8'h32: quad <= 1'b1;
                                    default: begin
                                        state      <= IGNORE;
                                        bus.err_o  <= 1'b1;
                                        bus.busy_o <= 1'b0;
                                    end
                                endcase
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr_sh <= full_addr[22:0];
                            if (cnt == 8'd0) begin
                                cur_addr <= full_addr[AW-1:0];
                                bcnt     <= 3'd0;
                                case (cmd_sh)
                                    8'h03: begin
                                        state          <= RDATA;
                                        bus.mem_req_o  <= 1'b1;
                                        bus.mem_we_o   <= 1'b0;
                                        bus.mem_addr_o <= full_addr[AW-1:0];
                                    end
                                    8'h6B: begin
                                        state <= DUMMY_S;
                                        cnt   <= 8'(DUMMY - 1);
                                    end
                                    default: begin
                                        state <= WDATA;
                                        bcnt  <= quad ? 3'd1 : 3'd7;
                                    end
                                endcase
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    DUMMY_S: begin
                        if (rise) begin
                            if (cnt == 8'(DUMMY - 1)) begin
                                bus.mem_req_o  <= 1'b1;
                                bus.mem_we_o   <= 1'b0;
                                bus.mem_addr_o <= cur_addr;
                            end
                            if (cnt == 8'd0) begin
                                state <= RDATA;
                                bcnt  <= 3'd0;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (fall) begin
                            bus.sd_oe <= quad ? 4'b1111 : 4'b0010;
                            if (bcnt == 3'd0) begin
                                // Byte boundary: consume the prefetched byte, fetch the next one.
                                cur_addr       <= cur_addr + 1'b1;
                                bus.mem_req_o  <= 1'b1;
                                bus.mem_we_o   <= 1'b0;
                                bus.mem_addr_o <= cur_addr + 1'b1;
                                if (quad) begin
                                    bus.sd_o <= pbuf[7:4];
                                    shreg    <= {pbuf[3:0], 4'h0};
                                    bcnt     <= 3'd1;
                                end else begin
                                    bus.sd_o <= {2'b00, pbuf[7], 1'b0};
                                    shreg    <= {pbuf[6:0], 1'b0};
                                    bcnt     <= 3'd7;
                                end
                            end else begin
                                bcnt <= bcnt - 1'b1;
                                if (quad) begin
                                    bus.sd_o <= shreg[7:4];
                                    shreg    <= {shreg[3:0], 4'h0};
                                end else begin
                                    bus.sd_o <= {2'b00, shreg[7], 1'b0};
                                    shreg    <= {shreg[6:0], 1'b0};
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (rise) begin
                            wsh <= wbyte[6:0];
                            if (bcnt == 3'd0) begin
                                bus.mem_req_o   <= 1'b1;
                                bus.mem_we_o    <= 1'b1;
                                bus.mem_addr_o  <= cur_addr;
                                bus.mem_wdata_o <= wbyte;
                                cur_addr        <= cur_addr + 1'b1;
                                bcnt            <= quad ? 3'd1 : 3'd7;
                            end else begin
                                bcnt <= bcnt - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: pin-level host driver, latency-programmable memory model,
// a transaction vector table and hand-written abort / bad-command / slow-memory sequences.
module tb_qspi_target;
    localparam int HP = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_target_if #(.AW(24)) bus ();
    qspi_target #(.AW(24), .DUMMY(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory model: grant after gnt_dly extra cycles, read data rv_dly cycles after grant.
    logic [7:0]  mem [int];
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    logic [23:0] log_addr [$];
    logic        log_we   [$];
    logic [7:0]  log_data [$];
    int          log_hold [$];
    int          stab_err = 0;
    int          drop_err = 0;

    initial begin : mem_model
        logic [23:0] a;
        logic        we;
        logic [7:0]  d;
        int          hold;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o === 1'b1) begin
                a    = bus.mem_addr_o;
                we   = bus.mem_we_o;
                d    = bus.mem_wdata_o;
                hold = 1;
                repeat (gnt_dly) begin
                    @(negedge clk);
                    if (bus.mem_req_o === 1'b1) hold++;
                    if (bus.mem_addr_o !== a || bus.mem_we_o !== we ||
                        bus.mem_wdata_o !== d || bus.mem_req_o !== 1'b1) stab_err++;
                end
                bus.mem_gnt_i = 1'b1;
                @(negedge clk);
                bus.mem_gnt_i = 1'b0;
                if (bus.mem_req_o !== 1'b0) drop_err++;
                log_addr.push_back(a);
                log_we.push_back(we);
                log_data.push_back(d);
                log_hold.push_back(hold);
                if (we) begin
                    mem[int'(a)] = d;
                end else begin
                    repeat (rv_dly - 1) @(negedge clk);
                    bus.mem_rdata_i  = mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
                    bus.mem_rvalid_i = 1'b1;
                    @(negedge clk);
                    bus.mem_rvalid_i = 1'b0;
                end
            end
        end
    end

    int err_cyc = 0;
    int oe_cyc  = 0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.err_o === 1'b1) err_cyc++;
            if (bus.sd_oe !== 4'h0) oe_cyc++;
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 80000 cycles");
        $fatal(1);
    end

    // Host side: drive data with SCLK low, sample sd_o just before the rise.
    logic [31:0] rx;
    logic [3:0]  oe_or;
    logic [3:0]  oe_and;
    logic        busy_and;

    task automatic sclk_pulse(input logic [3:0] d, input bit quad);
        bus.sclk_i = 1'b0;
        bus.sd_i   = d;
        wait_clk(HP);
        rx       = quad ? {rx[27:0], bus.sd_o} : {rx[30:0], bus.sd_o[1]};
        oe_or    = oe_or | bus.sd_oe;
        oe_and   = oe_and & bus.sd_oe;
        busy_and = busy_and & bus.busy_o;
        bus.sclk_i = 1'b1;
        wait_clk(HP);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sclk_pulse({3'b000, v[i]}, 1'b0);
    endtask

    task automatic cs_begin();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
        log_hold.delete();
        bus.cs_i = 1'b0;
        wait_clk(6);
    endtask

    // The closing SCLK fall coincides with CS high, so it never starts another byte.
    task automatic cs_end();
        bus.sclk_i = 1'b0;
        bus.cs_i   = 1'b1;
        wait_clk(16);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nclk,
                           input logic [31:0] din);
        bit quad;
        quad = (cmd == 8'h6B) || (cmd == 8'h32);
        cs_begin();
        send_bits({24'h0, cmd}, 8);
        send_bits({8'h0, addr}, 24);
        if (cmd == 8'h6B) for (int i = 0; i < 8; i++) sclk_pulse(4'h0, 1'b0);
        rx       = 32'h0;
        oe_or    = 4'h0;
        oe_and   = 4'hF;
        busy_and = 1'b1;
        for (int k = nclk - 1; k >= 0; k--)
            sclk_pulse(quad ? din[4*k +: 4] : {3'b000, din[k]}, quad);
        cs_end();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nclk;
        logic [31:0] din;
        logic [31:0] exp_rx;
        logic [3:0]  exp_oe;
        int          exp_nreq;
        logic        exp_we;
        logic [23:0] exp_a0;
        logic [23:0] exp_an;
        logic [7:0]  exp_d0;
        logic [7:0]  exp_dn;
    } vec_t;

    initial begin : main
        vec_t vecs [7];
        int   nbad;
        int   e0;
        int   o0;

        vecs[0] = '{8'h03, 24'h000010, 32, 32'h0,    32'hA53C_FF01, 4'h2, 5, 1'b0, 24'h000010, 24'h000014, 8'h00, 8'h00};
        vecs[1] = '{8'h03, 24'h000011, 8,  32'h0,    32'h0000_003C, 4'h2, 2, 1'b0, 24'h000011, 24'h000012, 8'h00, 8'h00};
        vecs[2] = '{8'h6B, 24'hFFFFFF, 4,  32'h0,    32'h0000_1234, 4'hF, 3, 1'b0, 24'hFFFFFF, 24'h000001, 8'h00, 8'h00};
        vecs[3] = '{8'h6B, 24'h000010, 4,  32'h0,    32'h0000_A53C, 4'hF, 3, 1'b0, 24'h000010, 24'h000012, 8'h00, 8'h00};
        vecs[4] = '{8'h32, 24'h000100, 4,  32'hDEAD, 32'h0,         4'h0, 2, 1'b1, 24'h000100, 24'h000101, 8'hDE, 8'hAD};
        vecs[5] = '{8'h02, 24'h000200, 8,  32'h5A,   32'h0,         4'h0, 1, 1'b1, 24'h000200, 24'h000200, 8'h5A, 8'h5A};
        vecs[6] = '{8'h03, 24'h000100, 16, 32'h0,    32'h0000_DEAD, 4'h2, 3, 1'b0, 24'h000100, 24'h000102, 8'h00, 8'h00};

        mem[32'h10] = 8'hA5;
        mem[32'h11] = 8'h3C;
        mem[32'h12] = 8'hFF;
        mem[32'h13] = 8'h01;
        mem[32'hFFFFFF] = 8'h12;
        mem[32'h0] = 8'h34;

        // Reset with SCLK toggling and CS low
        bus.sclk_i = 1'b0;
        bus.cs_i   = 1'b0;
        bus.sd_i   = 4'hF;
        rst        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_clk(2);
            bus.sclk_i = ~bus.sclk_i;
        end
        check("rst_sd_o", {28'h0, bus.sd_o}, 32'h0);
        check("rst_sd_oe", {28'h0, bus.sd_oe}, 32'h0);
        check("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we_o}, 32'h0);
        check("rst_mem_addr", {8'h0, bus.mem_addr_o}, 32'h0);
        check("rst_mem_wdata", {24'h0, bus.mem_wdata_o}, 32'h0);
        check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
        check("rst_err", {31'h0, bus.err_o}, 32'h0);
        bus.sclk_i = 1'b0;
        bus.cs_i   = 1'b1;
        bus.sd_i   = 4'h0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(12);

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].cmd, vecs[v].addr, vecs[v].nclk, vecs[v].din);
            check($sformatf("v%0d_data", v), rx, vecs[v].exp_rx);
            check($sformatf("v%0d_oe_or", v), {28'h0, oe_or}, {28'h0, vecs[v].exp_oe});
            check($sformatf("v%0d_oe_and", v), {28'h0, oe_and}, {28'h0, vecs[v].exp_oe});
            check($sformatf("v%0d_busy_in_txn", v), {31'h0, busy_and}, 32'h1);
            check($sformatf("v%0d_busy_after", v), {31'h0, bus.busy_o}, 32'h0);
            check($sformatf("v%0d_oe_after", v), {28'h0, bus.sd_oe}, 32'h0);
            check($sformatf("v%0d_nreq", v), log_addr.size(), vecs[v].exp_nreq);
            check($sformatf("v%0d_addr_first", v),
                  log_addr.size() > 0 ? {8'h0, log_addr[0]} : 32'hDEAD_BEEF, {8'h0, vecs[v].exp_a0});
            check($sformatf("v%0d_addr_last", v),
                  log_addr.size() > 0 ? {8'h0, log_addr[log_addr.size()-1]} : 32'hDEAD_BEEF,
                  {8'h0, vecs[v].exp_an});
            nbad = 0;
            for (int i = 0; i < log_we.size(); i++) if (log_we[i] !== vecs[v].exp_we) nbad++;
            check($sformatf("v%0d_we_dir", v), nbad, 0);
            if (vecs[v].exp_we) begin
                check($sformatf("v%0d_wdata_first", v),
                      log_data.size() > 0 ? {24'h0, log_data[0]} : 32'hDEAD_BEEF, {24'h0, vecs[v].exp_d0});
                check($sformatf("v%0d_wdata_last", v),
                      log_data.size() > 0 ? {24'h0, log_data[log_data.size()-1]} : 32'hDEAD_BEEF,
                      {24'h0, vecs[v].exp_dn});
            end
        end

        // Abort a single write after 5 data bits, then a full write must land cleanly
        cs_begin();
        send_bits(32'h02, 8);
        send_bits(32'h000300, 24);
        send_bits(32'h16, 5);
        cs_end();
        check("abort_no_write", log_addr.size(), 0);
        run_txn(8'h02, 24'h000300, 8, 32'hC3);
        check("post_abort_nreq", log_addr.size(), 1);
        check("post_abort_addr", log_addr.size() > 0 ? {8'h0, log_addr[0]} : 32'hDEAD_BEEF, 32'h300);
        check("post_abort_data", log_data.size() > 0 ? {24'h0, log_data[0]} : 32'hDEAD_BEEF, 32'hC3);

        // Unsupported command 0x9F
        check("no_spurious_err", err_cyc, 0);
        e0 = err_cyc;
        o0 = oe_cyc;
        cs_begin();
        send_bits(32'h9F, 8);
        wait_clk(4);
        check("badcmd_err_pulse", err_cyc - e0, 1);
        check("badcmd_busy_low", {31'h0, bus.busy_o}, 32'h0);
        send_bits(32'h000010, 24);
        send_bits(32'hA5, 8);
        check("badcmd_no_req", log_addr.size(), 0);
        check("badcmd_oe_quiet", oe_cyc - o0, 0);
        cs_end();
        check("badcmd_err_single", err_cyc - e0, 1);

        // Slow memory on a single read
        gnt_dly = 3;
        rv_dly  = 2;
        run_txn(8'h03, 24'h000012, 8, 32'h0);
        check("slow_data", rx, 32'hFF);
        check("slow_req_hold", log_hold.size() > 0 ? log_hold[0] : -1, 4);
        check("slow_nreq", log_addr.size(), 2);
        check("req_stable", stab_err, 0);
        check("req_drop_after_gnt", drop_err, 0);
        gnt_dly = 0;
        rv_dly  = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/qspi_target.md
# qspi_target

Device-side QSPI responder: the far end of the team's QSPI host controller, used as an on-chip flash/SRAM stand-in for loopback and for boot-path verification. It oversamples the host's SCLK/CS/SD pins in the system clock domain, decodes a command byte, a 24-bit address and optional dummy cycles, then streams bytes out of, or into, a byte-wide memory port. Address auto-increments per byte.

## Interface
- AW, 24: memory address width; the wire address is always 24 bits, truncated to AW.
- DUMMY, 8: dummy SCLK cycles for quad read.

- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- sclk_i  in  1  host SPI clock (mode 0), asynchronous
- cs_i  in  1  chip select, active-low, asynchronous
- sd_i  in  4  data lines from host; sd_i[0] is MOSI in single mode
- sd_o  out  4  data lines to host; sd_o[1] is MISO in single mode
- sd_oe  out  4  per-line output enable
- mem_req_o  out  1  memory request, held until granted
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  AW  byte address
- mem_wdata_o  out  8  write byte
- mem_gnt_i  in  1  request accepted
- mem_rdata_i  in  8  read byte
- mem_rvalid_i  in  1  rdata valid; arrives one or more cycles after gnt
- busy_o  out  1  CS asserted and the command is not ignored
- err_o  out  1  one-cycle pulse on an unsupported command

## Operation
- sclk_i, cs_i and sd_i pass through 2-flop synchronizers. Edge detect on synchronized SCLK gives rise and fall strobes.
- Rising strobe samples input lines. Falling strobe shifts output lines.
- Commands are always received single-bit on sd_i[0], MSB first.
- Supported commands:
  - 0x03: single read
  - 0x6B: quad output read, with DUMMY dummy cycles
  - 0x02: single write
  - 0x32: quad input write
- Any other command: pulse err_o and enter IGNORE.
- Address: 24 bits, single-bit, MSB first, on all commands.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD on CS falling.
  - CMD → ADDR after 8 rises.
  - ADDR → DUMMY (0x6B), or RDATA (0x03), or WDATA (0x02, 0x32) after 24 rises.
  - DUMMY → RDATA after DUMMY rises.
  - Any state → IDLE on CS high.
- Read path:
  - Issue a read request for the current address on the last address rise (0x03) or the first dummy rise (0x6B).
  - At each byte start, load the prefetched byte into the shift register and prefetch address+1.
  - Bits go out MSB first: 1 bit per fall on sd_o[1] with sd_oe=4'b0010 (0x03), or a nibble on sd_o[3:0] with sd_oe=4'b1111 (0x6B).
  - The first bit/nibble is driven on the fall preceding the first data rise.
- Write path:
  - Assemble bytes from sd_i[0] (0x02: 8 rises) or sd_i[3:0] (0x32: 2 rises, high nibble first).
  - Each completed byte issues a write request at the current address, then the address increments.
- Address arithmetic: wraps modulo 2^AW; 0xFFFFFF+1 → 0.
- CS deassert mid-operation:
  - sd_oe goes to 0 and the FSM returns to IDLE.
  - A partial write byte is discarded.
  - An outstanding mem_req_o stays held until mem_gnt_i. Any rvalid for an aborted read is dropped.
  - A new CS falling is not accepted until no request is outstanding.
- Reset values: sd_o=0, sd_oe=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, err_o=0; FSM in IDLE.

## Timing
- Pin to strobe: 3 clk_i cycles (2 sync + 1 edge register).
- Host constraints:
  - SCLK high and low each ≥ 8 clk_i.
  - CS setup before the first SCLK rise ≥ 4 clk_i.
  - CS high time ≥ 8 clk_i.
- Memory constraint: gnt plus rvalid within 6 clk_i of mem_req_o assertion. If rdata is late, the previous shift-register byte is repeated.
- mem_req_o asserts the cycle after the triggering strobe. It holds mem_addr_o, mem_we_o and mem_wdata_o stable until the gnt cycle and drops the cycle after.
- sd_o/sd_oe update in the cycle after the fall strobe.
- err_o fires the cycle after the 8th command rise.
- busy_o rises the cycle after CS-low is synchronized and falls the cycle after CS-high is synchronized.

## Test plan
- Reset: assert rst_i with SCLK toggling → all outputs 0, no mem_req_o.
- Single read: memory[0x000010..13]=0xA5,0x3C,0xFF,0x01; host sends 0x03, addr 0x000010, clocks 32 bits → MISO returns A5 3C FF 01, reads at addresses 0x10–0x14.
- Quad read with wrap: memory[0xFFFFFF]=0x12, memory[0]=0x34; 0x6B, addr 0xFFFFFF, 8 dummy cycles, 4 nibble clocks → nibbles 1,2,3,4 on sd_o, sd_oe=4'hF.
- Quad write then single write:
  - 0x32 addr 0x000100, nibbles DE AD → writes 0xDE@0x100, 0xAD@0x101.
  - 0x02 addr 0x000200, byte 0x5A → write 0x5A@0x200.
- Abort and bad command:
  - 0x02 with 5 data bits then CS high → no write; next transaction works.
  - Command 0x9F → err_o single pulse, sd_oe stays 0, no mem_req_o until CS high.
- Slow memory: gnt delayed 3 cycles, rvalid 2 more, on a 0x03 read → mem_req_o held stable for 4 cycles, correct byte output.
